// File: rtl/core_savestate_seq.sv
// Savestate sequencer: freezes the core, then copies core state into the
// savestate buffer RAM (save) or from the buffer back into the core (load).
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   savestate_start / _load        level requests; rising edge starts a process
//   savestate_{start,load}_ack     1-cycle acceptance pulse
//   savestate_{start,load}_busy    process running
//   savestate_{start,load}_ok/err  sticky result until next process of that type
//   pause_req / pause_ack          core freeze handshake
//   core_addr, core_rd, core_rd_data, core_rd_valid   core state read (variable latency)
//   core_wr, core_wr_data, core_wr_ready              core state write (held until ready)
//   buf_addr, buf_wr, buf_wr_data, buf_rd, buf_rd_data buffer RAM (read latency 1)
module core_savestate_seq #(
   parameter int unsigned WORDS   = 1024,
   parameter int unsigned AW      = 10,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          savestate_start,
   output logic          savestate_start_ack,
   output logic          savestate_start_busy,
   output logic          savestate_start_ok,
   output logic          savestate_start_err,
   input  logic          savestate_load,
   output logic          savestate_load_ack,
   output logic          savestate_load_busy,
   output logic          savestate_load_ok,
   output logic          savestate_load_err,
   output logic          pause_req,
   input  logic          pause_ack,
   output logic [AW-1:0] core_addr,
   output logic          core_rd,
   input  logic [31:0]   core_rd_data,
   input  logic          core_rd_valid,
   output logic          core_wr,
   output logic [31:0]   core_wr_data,
   input  logic          core_wr_ready,
   output logic [AW-1:0] buf_addr,
   output logic          buf_wr,
   output logic [31:0]   buf_wr_data,
   output logic          buf_rd,
   input  logic [31:0]   buf_rd_data
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE, PAUSE, SAVE_RD, SAVE_WAIT, SAVE_WR,
      LOAD_RD, LOAD_DATA, LOAD_WR, RESUME, FINISH
   } state_t;

   state_t        state;
   logic          start_q;
   logic          load_q;
   logic          armed;     // blocks a level already high at reset release
   logic          is_load;
   logic          err_flag;
   logic [AW-1:0] idx;
   logic [CW-1:0] cnt;

   logic start_edge_c;
   logic load_edge_c;

   assign start_edge_c = armed & savestate_start & ~start_q;
   assign load_edge_c  = armed & savestate_load  & ~load_q;

   // Sequencer: state, index, counters and all registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                <= IDLE;
         start_q              <= 1'b0;
         load_q               <= 1'b0;
         armed                <= 1'b0;
         is_load              <= 1'b0;
         err_flag             <= 1'b0;
         idx                  <= '0;
         cnt                  <= '0;
         savestate_start_ack  <= 1'b0;
         savestate_start_busy <= 1'b0;
         savestate_start_ok   <= 1'b0;
         savestate_start_err  <= 1'b0;
         savestate_load_ack   <= 1'b0;
         savestate_load_busy  <= 1'b0;
         savestate_load_ok    <= 1'b0;
         savestate_load_err   <= 1'b0;
         pause_req            <= 1'b0;
         core_addr            <= '0;
         core_rd              <= 1'b0;
         core_wr              <= 1'b0;
         core_wr_data         <= '0;
         buf_addr             <= '0;
         buf_wr               <= 1'b0;
         buf_wr_data          <= '0;
         buf_rd               <= 1'b0;
      end else begin
         start_q             <= savestate_start;
         load_q              <= savestate_load;
         armed               <= 1'b1;
         savestate_start_ack <= 1'b0;
         savestate_load_ack  <= 1'b0;

         case (state)
            IDLE: begin
               // save wins when both edges land in the same cycle
               if (start_edge_c) begin
                  state                <= PAUSE;
                  is_load              <= 1'b0;
                  err_flag             <= 1'b0;
                  cnt                  <= '0;
                  pause_req            <= 1'b1;
                  savestate_start_ack  <= 1'b1;
                  savestate_start_busy <= 1'b1;
                  savestate_start_ok   <= 1'b0;
                  savestate_start_err  <= 1'b0;
               end else if (load_edge_c) begin
                  state               <= PAUSE;
                  is_load             <= 1'b1;
                  err_flag            <= 1'b0;
                  cnt                 <= '0;
                  pause_req           <= 1'b1;
                  savestate_load_ack  <= 1'b1;
                  savestate_load_busy <= 1'b1;
                  savestate_load_ok   <= 1'b0;
                  savestate_load_err  <= 1'b0;
               end
            end
            PAUSE: begin
               if (pause_ack) begin
                  idx <= '0;
                  if (is_load) begin
                     state    <= LOAD_RD;
                     buf_rd   <= 1'b1;
                     buf_addr <= '0;
                  end else begin
                     state     <= SAVE_RD;
                     core_rd   <= 1'b1;
                     core_addr <= '0;
                  end
               end else if (cnt == CNT_MAX) begin
                  state     <= RESUME;
                  err_flag  <= 1'b1;
                  pause_req <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SAVE_RD: begin
               core_rd <= 1'b0;
               state   <= SAVE_WAIT;
            end
            SAVE_WAIT: begin
               if (core_rd_valid) begin
                  state       <= SAVE_WR;
                  buf_wr      <= 1'b1;
                  buf_addr    <= idx;
                  buf_wr_data <= core_rd_data;
               end
            end
            SAVE_WR: begin
               buf_wr <= 1'b0;
               if (idx == LAST_IDX) begin
                  state     <= RESUME;
                  pause_req <= 1'b0;
               end else begin
                  idx       <= idx + AW'(1);
                  state     <= SAVE_RD;
                  core_rd   <= 1'b1;
                  core_addr <= idx + AW'(1);
               end
            end
            LOAD_RD: begin
               buf_rd <= 1'b0;
               state  <= LOAD_DATA;
            end
            LOAD_DATA: begin
               state        <= LOAD_WR;
               core_wr      <= 1'b1;
               core_addr    <= idx;
               core_wr_data <= buf_rd_data;
            end
            LOAD_WR: begin
               if (core_wr_ready) begin
                  core_wr <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state     <= RESUME;
                     pause_req <= 1'b0;
                  end else begin
                     idx      <= idx + AW'(1);
                     state    <= LOAD_RD;
                     buf_rd   <= 1'b1;
                     buf_addr <= idx + AW'(1);
                  end
               end
            end
            RESUME: begin
               state <= FINISH;
            end
            FINISH: begin
               if (is_load) begin
                  savestate_load_busy <= 1'b0;
                  savestate_load_ok   <= ~err_flag;
                  savestate_load_err  <= err_flag;
               end else begin
                  savestate_start_busy <= 1'b0;
                  savestate_start_ok   <= ~err_flag;
                  savestate_start_err  <= err_flag;
               end
               err_flag <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_savestate_seq.sv
// Directed testbench for core_savestate_seq (WORDS=4, TIMEOUT=8) with small
// behavioural models of the core, the pause handshake and the buffer RAM.
module tb_core_savestate_seq;

   localparam int unsigned WORDS   = 4;
   localparam int unsigned AW      = 4;
   localparam int unsigned TIMEOUT = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          savestate_start, savestate_load;
   logic          start_ack, start_busy, start_ok, start_err;
   logic          load_ack, load_busy, load_ok, load_err;
   logic          pause_req;
   logic          pause_ack = 1'b0;
   logic [AW-1:0] core_addr, buf_addr;
   logic          core_rd, core_wr, buf_rd, buf_wr;
   logic [31:0]   core_rd_data = '0;
   logic          core_rd_valid = 1'b0;
   logic [31:0]   core_wr_data, buf_wr_data;
   logic          core_wr_ready;
   logic [31:0]   buf_rd_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   core_savestate_seq #(.WORDS(WORDS), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .savestate_start(savestate_start),
      .savestate_start_ack(start_ack), .savestate_start_busy(start_busy),
      .savestate_start_ok(start_ok), .savestate_start_err(start_err),
      .savestate_load(savestate_load),
      .savestate_load_ack(load_ack), .savestate_load_busy(load_busy),
      .savestate_load_ok(load_ok), .savestate_load_err(load_err),
      .pause_req(pause_req), .pause_ack(pause_ack),
      .core_addr(core_addr), .core_rd(core_rd),
      .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid),
      .core_wr(core_wr), .core_wr_data(core_wr_data), .core_wr_ready(core_wr_ready),
      .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_wr_data(buf_wr_data),
      .buf_rd(buf_rd), .buf_rd_data(buf_rd_data)
   );

   always #5 clk = ~clk;

   // Pause handshake: core acknowledges one cycle after the request when enabled
   logic ack_en = 1'b1;
   always @(posedge clk) pause_ack <= pause_req & ack_en;

   // Core read side: data 0xA0+addr returned 2 cycles after core_rd
   logic          rd_v1 = 1'b0;
   logic [AW-1:0] rd_a1 = '0;
   always @(posedge clk) begin
      rd_v1         <= core_rd;
      rd_a1         <= core_addr;
      core_rd_valid <= rd_v1;
      core_rd_data  <= 32'hA0 + 32'(rd_a1);
   end

   // Core write side: stalls 3 cycles on word 2, logs each accepted write
   int          stall_run   = 0;
   int          stall_total = 0;
   int          wr_count    = 0;
   logic [31:0] wr_log [0:63];
   assign core_wr_ready = core_wr && ((core_addr != AW'(2)) || (stall_run >= 3));
   always @(posedge clk) begin
      if (core_wr && !core_wr_ready) begin
         stall_run   <= stall_run + 1;
         stall_total <= stall_total + 1;
      end else if (!core_wr) begin
         stall_run <= 0;
      end
      if (core_wr && core_wr_ready) begin
         wr_log[wr_count[5:0]] <= core_wr_data;
         wr_count              <= wr_count + 1;
      end
   end

   // Buffer RAM with 1-cycle read latency; tb_wr is a bench-side preload port
   logic [31:0]   mem [0:15];
   logic          tb_wr = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [31:0]   tb_data = '0;
   always @(posedge clk) begin
      if (buf_wr)     mem[buf_addr] <= buf_wr_data;
      else if (tb_wr) mem[tb_addr]  <= tb_data;
      if (buf_rd)     buf_rd_data   <= mem[buf_addr];
   end

   // Event monitors
   int start_ack_cnt = 0, load_ack_cnt = 0, load_busy_cnt = 0;
   int core_rd_cnt = 0, buf_wr_cnt = 0;
   always @(posedge clk) begin
      if (start_ack) start_ack_cnt <= start_ack_cnt + 1;
      if (load_ack)  load_ack_cnt  <= load_ack_cnt + 1;
      if (load_busy) load_busy_cnt <= load_busy_cnt + 1;
      if (core_rd)   core_rd_cnt   <= core_rd_cnt + 1;
      if (buf_wr)    buf_wr_cnt    <= buf_wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"},
            {19'b0, start_ack, start_busy, start_ok, start_err, load_ack, load_busy,
             load_ok, load_err, pause_req, core_rd, core_wr, buf_rd, buf_wr}, 32'h0);
      check({tag, "_addr"}, {24'b0, core_addr, buf_addr}, 32'h0);
      check({tag, "_data"}, core_wr_data | buf_wr_data, 32'h0);
   endtask

   // which: 0 save done, 1 load done, 2 save reading word 1
   task automatic wait_for(input int which, input int budget, input string tag, output int n);
      logic hit;
      n = 0;
      forever begin
         case (which)
            0:       hit = start_ok | start_err;
            1:       hit = load_ok | load_err;
            default: hit = core_rd && (core_addr == AW'(1));
         endcase
         if (hit || n >= budget) break;
         @(negedge clk);
         n++;
      end
      if (!hit) check({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   // Raise a request, check the ack lands one cycle after the edge, then drop it
   task automatic fire(input bit ld);
      @(posedge clk); #1;
      if (ld) savestate_load = 1'b1; else savestate_start = 1'b1;
      @(negedge clk);
      check("ack_not_early", {31'b0, ld ? load_ack : start_ack}, 32'h0);
      @(negedge clk);
      check("ack_pulse", {31'b0, ld ? load_ack : start_ack}, 32'h1);
      check("busy_rise", {31'b0, ld ? load_busy : start_busy}, 32'h1);
      check("ok_clear",  {31'b0, ld ? load_ok : start_ok}, 32'h0);
      check("pause_rise", {31'b0, pause_req}, 32'h1);
      @(posedge clk); #1;
      if (ld) savestate_load = 1'b0; else savestate_start = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", {31'b0, ld ? load_ack : start_ack}, 32'h0);
   endtask

   task automatic preload(input logic [31:0] d0, input logic [31:0] step);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         tb_wr = 1'b1; tb_addr = AW'(i); tb_data = d0 + step * 32'(i);
      end
      @(posedge clk); #1;
      tb_wr = 1'b0;
   endtask

   initial begin
      int n, base_ack, base_lack, base_lbusy, base_rd, base_bw, base_wr;
      reset_n = 1'b0;
      savestate_start = 1'b1;   // already high at release: must not count
      savestate_load  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("level_at_release_no_ack", 32'(start_ack_cnt), 32'h0);
      check("level_at_release_no_busy", {31'b0, start_busy}, 32'h0);
      @(posedge clk); #1 savestate_start = 1'b0;

      // Save: buffer receives 0xA0..0xA3
      preload(32'h0, 32'h0);
      base_ack = start_ack_cnt;
      fire(1'b0);
      wait_for(0, 200, "save", n);
      check("save_ok", {31'b0, start_ok}, 32'h1);
      check("save_err", {31'b0, start_err}, 32'h0);
      check("save_busy_drop", {31'b0, start_busy}, 32'h0);
      check("save_pause_low", {31'b0, pause_req}, 32'h0);
      check("save_ack_count", 32'(start_ack_cnt - base_ack), 32'h1);
      for (int i = 0; i < 4; i++) check($sformatf("save_buf%0d", i), mem[i], 32'hA0 + 32'(i));

      // Load: core receives 0x11..0x44 in order with a stall on word 2
      preload(32'h11, 32'h11);
      base_wr = wr_count;
      fire(1'b1);
      wait_for(1, 200, "load", n);
      check("load_ok", {31'b0, load_ok}, 32'h1);
      check("load_err", {31'b0, load_err}, 32'h0);
      check("load_write_count", 32'(wr_count - base_wr), 32'h4);
      for (int i = 0; i < 4; i++)
         check($sformatf("load_core%0d", i), wr_log[base_wr + i], 32'h11 * 32'(i + 1));
      check("load_stall_seen", 32'(stall_total), 32'h3);
      check("save_ok_held", {31'b0, start_ok}, 32'h1);

      // Timeout: no pause_ack, error appears after TIMEOUT pause cycles
      ack_en = 1'b0;
      base_rd = core_rd_cnt; base_bw = buf_wr_cnt;
      fire(1'b0);
      wait_for(0, 100, "tmo", n);
      check("tmo_latency", 32'(n), 32'd9);
      check("tmo_err", {31'b0, start_err}, 32'h1);
      check("tmo_ok", {31'b0, start_ok}, 32'h0);
      check("tmo_no_core_rd", 32'(core_rd_cnt - base_rd), 32'h0);
      check("tmo_no_buf_wr", 32'(buf_wr_cnt - base_bw), 32'h0);
      check("tmo_pause_low", {31'b0, pause_req}, 32'h0);
      check("tmo_load_ok_held", {31'b0, load_ok}, 32'h1);
      ack_en = 1'b1;

      // Simultaneous edges, then a re-trigger while busy
      base_ack = start_ack_cnt; base_lack = load_ack_cnt; base_lbusy = load_busy_cnt;
      @(posedge clk); #1;
      savestate_start = 1'b1; savestate_load = 1'b1;
      repeat (3) @(posedge clk); #1 savestate_start = 1'b0;
      @(posedge clk); #1 savestate_start = 1'b1;
      wait_for(0, 200, "both", n);
      @(negedge clk);
      check("both_start_ok", {31'b0, start_ok}, 32'h1);
      check("both_single_start_ack", 32'(start_ack_cnt - base_ack), 32'h1);
      check("both_no_load_ack", 32'(load_ack_cnt - base_lack), 32'h0);
      check("both_no_load_busy", 32'(load_busy_cnt - base_lbusy), 32'h0);
      check("both_load_ok_held", {31'b0, load_ok}, 32'h1);
      @(posedge clk); #1;
      savestate_start = 1'b0; savestate_load = 1'b0;

      // Reset during word 1 of a save, then a clean save
      preload(32'h0, 32'h0);
      fire(1'b0);
      wait_for(2, 100, "word1", n);
      #1 reset_n = 1'b0;
      #1 check_all_zero("midreset");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_no_ok", {30'b0, start_ok, start_err}, 32'h0);
      fire(1'b0);
      wait_for(0, 200, "resave", n);
      check("resave_ok", {31'b0, start_ok}, 32'h1);
      check("resave_buf3", mem[3], 32'hA3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, got hang expected finish");
      $fatal(1);
   end

endmodule
